// File: rtl/uart_ftw_loader.sv
// uart_ftw_loader: receives 8N1 UART frames (A5, CMD, 4 payload bytes MSB-first)
// and loads the selected 32-bit DDS tuning word.
// Optional feature macro FTW_CHECKSUM_EN: adds a trailing XOR checksum byte
// (CMD ^ payload bytes) that must match before the commit.
// Ports:
//   clk       - single clock, rising edge
//   rst_n     - asynchronous active-low reset
//   rx        - UART serial input, idle high, asynchronous to clk
//   ftw0/ftw1 - live tuning words (freq_sel = 0 / 1)
//   ftw_stb   - one-cycle pulse when ftw0 or ftw1 is updated
//   frame_err - one-cycle pulse on framing error, bad command, bad checksum or timeout
//   busy      - parser mid-frame or receiver mid-byte
module uart_ftw_loader #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [31:0] FTW0_INIT    = 32'h0083_126F,
  parameter logic [31:0] FTW1_INIT    = 32'h0106_24DD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [31:0] ftw0,
  output logic [31:0] ftw1,
  output logic        ftw_stb,
  output logic        frame_err,
  output logic        busy
);

  localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned TO_CYCLES = 16 * CLKS_PER_BIT;
  localparam int unsigned TO_W      = $clog2(TO_CYCLES + 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYCLES - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {
    P_SYNC, P_CMD, P_B3, P_B2, P_B1, P_B0
`ifdef FTW_CHECKSUM_EN
    , P_CHK
`endif
  } p_state_e;

  logic             rx_meta_q, rx_s_q;
  rx_state_e        rx_st_q, rx_st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;
  logic             wait_q, wait_d;
  logic             byte_vld_c, stop_err_c;

  p_state_e         p_q, p_d;
  logic             sel_q, sel_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [31:0]      ftw0_q, ftw0_d, ftw1_q, ftw1_d;
  logic             stb_q, stb_d, ferr_q, ferr_d, busy_q, busy_d;
  logic             commit_c;
  logic [31:0]      commit_val_c;
`ifdef FTW_CHECKSUM_EN
  logic [7:0]       chk_q, chk_d;
`endif

  // Two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receiver next-state: mid-bit sampling counted from the start-bit midpoint
  always_comb begin
    rx_st_d    = rx_st_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    data_d     = data_q;
    wait_d     = wait_q;
    byte_vld_c = 1'b0;
    stop_err_c = 1'b0;
    case (rx_st_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s_q) rx_st_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          rx_st_d = rx_s_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d  = '0;
          data_d = {rx_s_q, data_q[7:1]};
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_st_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        // After a bad stop bit, hold here until the line returns high
        if (wait_q) begin
          if (rx_s_q) begin
            wait_d  = 1'b0;
            rx_st_d = RX_IDLE;
          end
        end else if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (rx_s_q) begin
            byte_vld_c = 1'b1;
            rx_st_d    = RX_IDLE;
          end else begin
            stop_err_c = 1'b1;
            wait_d     = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // Parser next-state, shadow assembly, commit and output pulses
  always_comb begin
    p_d          = p_q;
    sel_d        = sel_q;
    shadow_d     = shadow_q;
    ftw0_d       = ftw0_q;
    ftw1_d       = ftw1_q;
    stb_d        = 1'b0;
    ferr_d       = stop_err_c;
    commit_c     = 1'b0;
    commit_val_c = {shadow_q[23:0], data_q};
`ifdef FTW_CHECKSUM_EN
    chk_d        = chk_q;
`endif
    // Inter-byte timeout only accumulates while mid-frame with the line idle
    if (p_q == P_SYNC || rx_st_q != RX_IDLE) to_d = '0;
    else                                     to_d = to_q + TO_W'(1);

    if (p_q != P_SYNC && stop_err_c) begin
      p_d = P_SYNC;
    end else if (p_q != P_SYNC && rx_st_q == RX_IDLE && to_q == TO_LAST) begin
      p_d    = P_SYNC;
      ferr_d = 1'b1;
    end else if (byte_vld_c) begin
      case (p_q)
        P_SYNC: if (data_q == 8'hA5) p_d = P_CMD;
        P_CMD: begin
          if (data_q[7:1] == 7'd0) begin
            sel_d = data_q[0];
            p_d   = P_B3;
`ifdef FTW_CHECKSUM_EN
            chk_d = data_q;
`endif
          end else begin
            ferr_d = 1'b1;
            p_d    = P_SYNC;
          end
        end
        P_B3, P_B2, P_B1: begin
          shadow_d = {shadow_q[23:0], data_q};
          p_d      = p_state_e'(p_q + 3'd1);
`ifdef FTW_CHECKSUM_EN
          chk_d    = chk_q ^ data_q;
`endif
        end
        P_B0: begin
          shadow_d = {shadow_q[23:0], data_q};
`ifdef FTW_CHECKSUM_EN
          chk_d    = chk_q ^ data_q;
          p_d      = P_CHK;
`else
          commit_c = 1'b1;
          p_d      = P_SYNC;
`endif
        end
`ifdef FTW_CHECKSUM_EN
        P_CHK: begin
          commit_val_c = shadow_q;
          if (data_q == chk_q) commit_c = 1'b1;
          else                 ferr_d   = 1'b1;
          p_d = P_SYNC;
        end
`endif
        default: p_d = P_SYNC;
      endcase
    end

    if (commit_c) begin
      stb_d = 1'b1;
      if (sel_q) ftw1_d = commit_val_c;
      else       ftw0_d = commit_val_c;
    end
    busy_d = (p_d != P_SYNC) || (rx_st_d != RX_IDLE);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st_q  <= RX_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      wait_q   <= 1'b0;
      p_q      <= P_SYNC;
      sel_q    <= 1'b0;
      shadow_q <= '0;
      to_q     <= '0;
      ftw0_q   <= FTW0_INIT;
      ftw1_q   <= FTW1_INIT;
      stb_q    <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef FTW_CHECKSUM_EN
      chk_q    <= '0;
`endif
    end else begin
      rx_st_q  <= rx_st_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      wait_q   <= wait_d;
      p_q      <= p_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      to_q     <= to_d;
      ftw0_q   <= ftw0_d;
      ftw1_q   <= ftw1_d;
      stb_q    <= stb_d;
      ferr_q   <= ferr_d;
      busy_q   <= busy_d;
`ifdef FTW_CHECKSUM_EN
      chk_q    <= chk_d;
`endif
    end
  end

  assign ftw0      = ftw0_q;
  assign ftw1      = ftw1_q;
  assign ftw_stb   = stb_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;

endmodule

// File: doc/uart_ftw_loader.md
UART_FTW_LOADER -- requirements
Module: uart_ftw_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clock cycles per UART bit (50 MHz / 115200 baud).
REQ-002 SHALL have parameter FTW0_INIT, default 32'h0083_126F, meaning the reset value of ftw0.
REQ-003 SHALL have parameter FTW1_INIT, default 32'h0106_24DD, meaning the reset value of ftw1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all flops on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port rx, input, 1 bit: UART serial line, 8N1, idle high, asynchronous to clk.
REQ-007 SHALL have port ftw0, output, 32 bits: tuning word consumed by the DDS when freq_sel=0.
REQ-008 SHALL have port ftw1, output, 32 bits: tuning word consumed by the DDS when freq_sel=1.
REQ-009 SHALL have port ftw_stb, output, 1 bit: one-cycle pulse on any ftw0/ftw1 update.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a UART framing error or an illegal frame.
REQ-011 SHALL have port busy, output, 1 bit: high while the parser is outside P_SYNC or the receiver is outside RX_IDLE.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer that resets to 1; all logic uses the synchronized rx_s.
REQ-013 Receiver SHALL implement the states RX_IDLE, RX_START, RX_DATA and RX_STOP.
REQ-014 RX_IDLE->RX_START SHALL occur on rx_s==0; at count CLKS_PER_BIT/2, rx_s==1 returns to RX_IDLE (glitch rejected), else the receiver enters RX_DATA.
REQ-015 RX_DATA SHALL sample 8 bits LSB-first, each CLKS_PER_BIT cycles after the previous sample (mid-bit).
REQ-016 RX_STOP SHALL sample after CLKS_PER_BIT cycles: rx_s==1 gives an internal byte_vld pulse that cycle; rx_s==0 gives a frame_err pulse, discards the byte and waits for rx_s==1 before RX_IDLE.
REQ-017 Parser SHALL implement the states P_SYNC, P_CMD, P_B3, P_B2, P_B1, P_B0 (plus P_CHK, REQ-029).
REQ-018 In P_SYNC, byte 0xA5 SHALL advance to P_CMD; any other byte SHALL be ignored with no error.
REQ-019 In P_CMD, 0x00 selects ftw0 and 0x01 selects ftw1 and SHALL advance to P_B3; any other value SHALL pulse frame_err and return to P_SYNC.
REQ-020 P_B3..P_B0 SHALL shift payload bytes MSB-first into a 32-bit shadow register; the live ftw0/ftw1 outputs stay unchanged during this.
REQ-021 Commit: the cycle after byte_vld of the final byte, the selected ftw SHALL load the shadow and ftw_stb SHALL be high for exactly that cycle; the parser returns to P_SYNC.
REQ-022 The unselected ftw SHALL never change on a commit.
REQ-023 A framing error in any parser state other than P_SYNC SHALL abort the frame: return to P_SYNC, no commit.
REQ-024 Inter-byte timeout: outside P_SYNC, 16*CLKS_PER_BIT cycles with the receiver in RX_IDLE SHALL abort to P_SYNC with a frame_err pulse.
REQ-025 Back-to-back frames with no idle gap SHALL all be accepted; no byte may be dropped.

Reset
REQ-026 While rst_n=0, outputs SHALL be: ftw0=FTW0_INIT, ftw1=FTW1_INIT, ftw_stb=0, frame_err=0, busy=0.
REQ-027 While rst_n=0, the receiver SHALL be in RX_IDLE and the parser in P_SYNC, with all counters and the shadow register at 0.
REQ-028 Reset assertion mid-frame SHALL discard the partial frame immediately; after release, reception resumes on the next start bit.

Configuration
REQ-029 With FTW_CHECKSUM_EN defined, P_B0 SHALL go to P_CHK; in P_CHK, a byte equal to the XOR of the CMD and the 4 payload bytes commits, and any other byte pulses frame_err with no commit.
REQ-030 Without FTW_CHECKSUM_EN, P_CHK SHALL not exist and the commit SHALL follow P_B0 directly.

Verification
REQ-031 Reset, then idle -> ftw0=FTW0_INIT, ftw1=FTW1_INIT, busy=0, no pulses.
REQ-032 Send A5 01 12 34 56 78 (plus checksum 0x09 if FTW_CHECKSUM_EN) -> ftw1=32'h12345678, one ftw_stb, ftw0 unchanged.
REQ-033 Send A5 02 -> frame_err pulse on the second byte; ftw0 and ftw1 unchanged; the next valid frame commits.
REQ-034 Send a 0x55 byte whose stop bit is driven low, inside a frame -> frame_err pulse, parser in P_SYNC, no commit.
REQ-035 Send a 0.3-bit-time low glitch on rx -> no byte_vld, no frame_err, receiver back in RX_IDLE.
REQ-036 Send A5 00 AA BB, then idle 20 bit-times -> frame_err pulse at 16 bit-times, no commit; pulse rst_n mid-frame -> outputs at init values.
